// File: rtl/fft_pkg.sv
// Shared constants and helpers for the FFT output stage.
// Contents:
//   N, LOG2N, DW : points per frame, index width, and width of each real/imag part.
//   CW           : width of one packed complex sample, {re, im}.
//   bitrev5      : reverses the 5 index bits.
package fft_pkg;

    localparam int unsigned N     = 32;
    localparam int unsigned LOG2N = 5;
    localparam int unsigned DW    = 24;
    localparam int unsigned CW    = 2 * DW;

    function automatic logic [LOG2N-1:0] bitrev5(input logic [LOG2N-1:0] idx);
        return {idx[0], idx[1], idx[2], idx[3], idx[4]};
    endfunction

endpackage

// File: rtl/reorder_bank.sv
// One 32 x CW register file bank for the reorder buffer.
// The write port is synchronous and the read port is combinational. The storage has no reset.
// Ports:
//   clk      : clock
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data, {re, im}
//   raddr_i  : read address
//   rdata_o  : read data, available in the same cycle
module reorder_bank
    import fft_pkg::*;
(
    input  logic             clk,
    input  logic             we_i,
    input  logic [LOG2N-1:0] waddr_i,
    input  logic [CW-1:0]    wdata_i,
    input  logic [LOG2N-1:0] raddr_i,
    output logic [CW-1:0]    rdata_o
);

    logic [CW-1:0] mem_q [N];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fft_out_reorder.sv
// Reorder buffer for the end of the 32-point SDF FFT.
// It turns the bit-reversed output stream into natural order X[0]..X[31].
// Two banks form a ping-pong pair: one bank fills while the other drains, so back-to-back
// frames do not stall.
// Ports:
//   clk, reset       : clock and asynchronous active-high reset
//   in_valid_i       : din_r_i/din_i_i carry a valid sample
//   din_r_i/din_i_i  : signed real/imag parts, in bit-reversed arrival order
//   out_valid_o      : outputs are valid this cycle
//   dout_r_o/dout_i_o: signed real/imag parts, in natural order
//   out_index_o      : natural frequency index k
//   frame_start_o    : one-cycle pulse with the k=0 output
module fft_out_reorder
    import fft_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid_i,
    input  logic [DW-1:0]    din_r_i,
    input  logic [DW-1:0]    din_i_i,
    output logic             out_valid_o,
    output logic [DW-1:0]    dout_r_o,
    output logic [DW-1:0]    dout_i_o,
    output logic [LOG2N-1:0] out_index_o,
    output logic             frame_start_o
);

    logic [LOG2N-1:0] wr_cnt_q, wr_cnt_d;
    logic [LOG2N-1:0] rd_cnt_q, rd_cnt_d;
    logic             bank_sel_q, bank_sel_d;
    logic             rd_active_q, rd_active_d;
    logic             out_valid_d, frame_start_d;
    logic [DW-1:0]    dout_r_d, dout_i_d;
    logic [LOG2N-1:0] out_index_d;

    logic             fill;
    logic             we0, we1;
    logic [CW-1:0]    wdata, rdata0, rdata1, rdata;

    // bank_sel_q selects the bank being written. The other bank is the one being read.
    assign fill  = in_valid_i && (wr_cnt_q == LOG2N'(N - 1));
    assign we0   = in_valid_i && !bank_sel_q;
    assign we1   = in_valid_i && bank_sel_q;
    assign wdata = {din_r_i, din_i_i};
    assign rdata = bank_sel_q ? rdata0 : rdata1;

    reorder_bank u_bank0 (
        .clk     (clk),
        .we_i    (we0),
        .waddr_i (bitrev5(wr_cnt_q)),
        .wdata_i (wdata),
        .raddr_i (rd_cnt_q),
        .rdata_o (rdata0)
    );

    reorder_bank u_bank1 (
        .clk     (clk),
        .we_i    (we1),
        .waddr_i (bitrev5(wr_cnt_q)),
        .wdata_i (wdata),
        .raddr_i (rd_cnt_q),
        .rdata_o (rdata1)
    );

    always_comb begin
        wr_cnt_d      = wr_cnt_q;
        rd_cnt_d      = rd_cnt_q;
        bank_sel_d    = bank_sel_q;
        rd_active_d   = rd_active_q;
        out_valid_d   = 1'b0;
        frame_start_d = 1'b0;
        dout_r_d      = dout_r_o;
        dout_i_d      = dout_i_o;
        out_index_d   = out_index_o;

        if (in_valid_i) begin
            wr_cnt_d = wr_cnt_q + LOG2N'(1);
        end

        if (rd_active_q) begin
            out_valid_d   = 1'b1;
            frame_start_d = (rd_cnt_q == '0);
            dout_r_d      = rdata[CW-1:DW];
            dout_i_d      = rdata[DW-1:0];
            out_index_d   = rd_cnt_q;
            rd_cnt_d      = rd_cnt_q + LOG2N'(1);
            if (rd_cnt_q == LOG2N'(N - 1)) begin
                rd_active_d = 1'b0;
            end
        end

        // A fill overrides the end of a read. This gives gapless back-to-back frames.
        // If a read is still in progress, the fill truncates it.
        if (fill) begin
            bank_sel_d  = !bank_sel_q;
            rd_active_d = 1'b1;
            rd_cnt_d    = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_cnt_q      <= '0;
            rd_cnt_q      <= '0;
            bank_sel_q    <= 1'b0;
            rd_active_q   <= 1'b0;
            out_valid_o   <= 1'b0;
            frame_start_o <= 1'b0;
            dout_r_o      <= '0;
            dout_i_o      <= '0;
            out_index_o   <= '0;
        end else begin
            wr_cnt_q      <= wr_cnt_d;
            rd_cnt_q      <= rd_cnt_d;
            bank_sel_q    <= bank_sel_d;
            rd_active_q   <= rd_active_d;
            out_valid_o   <= out_valid_d;
            frame_start_o <= frame_start_d;
            dout_r_o      <= dout_r_d;
            dout_i_o      <= dout_i_d;
            out_index_o   <= out_index_d;
        end
    end

endmodule

// File: tb/tb_fft_out_reorder.sv
// Directed self-checking bench for fft_out_reorder.
// A negedge monitor records every output cycle.
// Each test task drives its stimulus and then compares the recorded cycles with expected
// values, which are computed by hand from the arrival index.
module tb_fft_out_reorder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [23:0] din_r, din_i;
    logic        out_valid, frame_start;
    logic [23:0] dout_r, dout_i;
    logic [4:0]  out_index;

    int n_tests = 0;
    int n_fail  = 0;

    logic        cap_v[$];
    logic        cap_fs[$];
    logic [4:0]  cap_idx[$];
    logic [23:0] cap_r[$];
    logic [23:0] cap_i[$];

    fft_out_reorder dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid_i    (in_valid),
        .din_r_i       (din_r),
        .din_i_i       (din_i),
        .out_valid_o   (out_valid),
        .dout_r_o      (dout_r),
        .dout_i_o      (dout_i),
        .out_index_o   (out_index),
        .frame_start_o (frame_start)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cap_v.push_back(out_valid);
        cap_fs.push_back(frame_start);
        cap_idx.push_back(out_index);
        cap_r.push_back(dout_r);
        cap_i.push_back(dout_i);
    end

    function automatic int br5(input int x);
        int r = 0;
        for (int b = 0; b < 5; b++) begin
            if (x[b]) r = r | (1 << (4 - b));
        end
        return r;
    endfunction

    task automatic clear_cap();
        cap_v.delete(); cap_fs.delete(); cap_idx.delete(); cap_r.delete(); cap_i.delete();
    endtask

    // Drive one cycle. Inputs change 1 ns after a posedge and are sampled at the next posedge.
    task automatic drive(input logic v, input logic [23:0] r, input logic [23:0] i);
        in_valid = v; din_r = r; din_i = i;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) drive(1'b0, 24'd999, 24'd999);
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; din_r = '0; din_i = '0;
        #1;
        n_tests++;
        if ({out_valid, frame_start, out_index, dout_r, dout_i} !== 55'd0) begin
            n_fail++;
            $display("FAIL reset_async got=%h want=0",
                     {out_valid, frame_start, out_index, dout_r, dout_i});
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        idle(5);
        n_tests++;
        if ({out_valid, frame_start, out_index, dout_r, dout_i} !== 55'd0) begin
            n_fail++;
            $display("FAIL reset_idle got=%h want=0",
                     {out_valid, frame_start, out_index, dout_r, dout_i});
        end
    endtask

    task automatic test_single_frame();
        int nv = 0;
        clear_cap();
        for (int n = 0; n < 32; n++) drive(1'b1, 24'(n), 24'(-n));
        idle(40);
        // The sample with arrival index 31 is taken at the edge after negedge 31.
        // X[0] is registered one edge later and is seen at negedge 33.
        for (int k = 0; k < 32; k++) begin
            logic [54:0] got, exp;
            got = {cap_v[33+k], cap_fs[33+k], cap_idx[33+k], cap_r[33+k], cap_i[33+k]};
            exp = {1'b1, (k == 0), 5'(k), 24'(br5(k)), 24'(-br5(k))};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL single_k%0d got=%h want=%h", k, got, exp);
            end
        end
        foreach (cap_v[j]) if (cap_v[j]) nv++;
        n_tests++;
        if (nv != 32) begin
            n_fail++;
            $display("FAIL single_valid_count got=%0d want=32", nv);
        end
        n_tests++;
        if (cap_v[32] !== 1'b0 || cap_v[65] !== 1'b0) begin
            n_fail++;
            $display("FAIL single_edges got=%b%b want=00", cap_v[32], cap_v[65]);
        end
    endtask

    task automatic test_back_to_back();
        int nv = 0, nfs = 0;
        clear_cap();
        for (int f = 0; f < 3; f++)
            for (int n = 0; n < 32; n++) drive(1'b1, 24'(100 * f + n), 24'(n));
        idle(40);
        for (int j = 0; j < 96; j++) begin
            logic [54:0] got, exp;
            int f, k;
            f = j / 32; k = j % 32;
            got = {cap_v[33+j], cap_fs[33+j], cap_idx[33+j], cap_r[33+j], cap_i[33+j]};
            exp = {1'b1, (k == 0), 5'(k), 24'(100 * f + br5(k)), 24'(br5(k))};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL b2b_f%0d_k%0d got=%h want=%h", f, k, got, exp);
            end
        end
        n_tests++;
        if (cap_r[33+33] !== 24'd116) begin
            n_fail++;
            $display("FAIL b2b_f1_k1_value got=%0d want=116", cap_r[66]);
        end
        foreach (cap_v[j]) begin
            if (cap_v[j]) nv++;
            if (cap_fs[j]) nfs++;
        end
        n_tests++;
        if (nv != 96 || nfs != 3) begin
            n_fail++;
            $display("FAIL b2b_counts got=%0d/%0d want=96/3", nv, nfs);
        end
    endtask

    task automatic test_gapped();
        int nv = 0;
        clear_cap();
        for (int n = 0; n < 32; n++) begin
            drive(1'b1, 24'(n), 24'(-n));
            drive(1'b0, 24'd7777, 24'd7777);
        end
        idle(40);
        // The last valid sample is taken at the edge after negedge 62, so X[0] is seen at negedge 64.
        for (int k = 0; k < 32; k++) begin
            logic [54:0] got, exp;
            got = {cap_v[64+k], cap_fs[64+k], cap_idx[64+k], cap_r[64+k], cap_i[64+k]};
            exp = {1'b1, (k == 0), 5'(k), 24'(br5(k)), 24'(-br5(k))};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL gapped_k%0d got=%h want=%h", k, got, exp);
            end
        end
        foreach (cap_v[j]) if (cap_v[j]) nv++;
        n_tests++;
        if (nv != 32 || cap_v[63] !== 1'b0) begin
            n_fail++;
            $display("FAIL gapped_valid got=%0d,%b want=32,0", nv, cap_v[63]);
        end
    endtask

    task automatic test_reset_mid_frame();
        int nv = 0;
        for (int n = 0; n < 20; n++) drive(1'b1, 24'(n), 24'd4444);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        clear_cap();
        for (int n = 0; n < 32; n++) drive(1'b1, 24'(n + 50), 24'd0);
        idle(40);
        for (int k = 0; k < 32; k++) begin
            logic [54:0] got, exp;
            got = {cap_v[33+k], cap_fs[33+k], cap_idx[33+k], cap_r[33+k], cap_i[33+k]};
            exp = {1'b1, (k == 0), 5'(k), 24'(50 + br5(k)), 24'd0};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL rstframe_k%0d got=%h want=%h", k, got, exp);
            end
        end
        foreach (cap_v[j]) if (cap_v[j]) nv++;
        n_tests++;
        if (nv != 32) begin
            n_fail++;
            $display("FAIL rstframe_valid_count got=%0d want=32", nv);
        end
    endtask

    task automatic test_reset_mid_read();
        int nv = 0;
        for (int n = 0; n < 32; n++) drive(1'b1, 24'(n + 200), 24'(n));
        idle(10);
        n_tests++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rstread_before got=%b want=1", out_valid);
        end
        #2 reset = 1'b1;
        #1;
        n_tests++;
        if ({out_valid, frame_start, out_index, dout_r, dout_i} !== 55'd0) begin
            n_fail++;
            $display("FAIL rstread_async got=%h want=0",
                     {out_valid, frame_start, out_index, dout_r, dout_i});
        end
        @(posedge clk);
        #1 reset = 1'b0;
        clear_cap();
        idle(40);
        foreach (cap_v[j]) if (cap_v[j]) nv++;
        n_tests++;
        if (nv != 0) begin
            n_fail++;
            $display("FAIL rstread_quiet got=%0d want=0", nv);
        end
    endtask

    task automatic test_extremes();
        clear_cap();
        for (int n = 0; n < 32; n++) begin
            if (n == 1) drive(1'b1, 24'h800000, 24'h7fffff);
            else        drive(1'b1, 24'(n), 24'(-n));
        end
        idle(40);
        n_tests++;
        if ({cap_v[49], cap_idx[49], cap_r[49], cap_i[49]} !== {1'b1, 5'd16, 24'h800000, 24'h7fffff}) begin
            n_fail++;
            $display("FAIL extreme_k16 got=%b %0d %h %h want=1 16 800000 7fffff",
                     cap_v[49], cap_idx[49], cap_r[49], cap_i[49]);
        end
        n_tests++;
        if ({cap_r[41], cap_i[41]} !== {24'd2, 24'hfffffe}) begin
            n_fail++;
            $display("FAIL extreme_k8 got=%h %h want=000002 fffffe", cap_r[41], cap_i[41]);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_gapped();
        test_reset_mid_frame();
        test_reset_mid_read();
        test_extremes();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
